led_comet_seq: RTL and testbench

- Upstream pattern source for the ws2812 chain driver; drives its led_num / rgb_data / write inputs.
- Every frame period it sweeps all LED indices, one write per cycle.
- Each sweep renders a "comet": a full-brightness head with a two-LED fading tail. The head advances one LED per frame, and the colour steps each time the head wraps.

---
 rtl/led_comet_seq.sv | 129 ++++++++++++
 tb/tb_led_comet_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_comet_seq.sv
// Comet pattern source for a ws2812 chain driver: once per frame, sweeps every LED index
// with a bright head, a two-LED fading tail, and a colour that steps each time the head wraps.
module led_comet_seq #(
   parameter int unsigned NUM_LEDS  = 40,
   parameter int unsigned FRAME_DIV = 524288
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  brightness,
   output logic [7:0]  led_num,
   output logic [23:0] rgb_data,
   output logic        write,
   output logic        frame_done,
   output logic [7:0]  head
);

   localparam int unsigned TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(FRAME_DIV - 1);
   localparam logic [7:0]    N8       = 8'(NUM_LEDS);
   localparam logic [7:0]    HEAD_MAX = 8'(NUM_LEDS - 1);
   localparam logic [8:0]    N9       = 9'(NUM_LEDS);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [7:0]      k;
   logic [7:0]      lq;
   logic [1:0]      c;
   logic            tick;

   logic [7:0]      k_idx;
   logic [7:0]      lvl_src;
   logic [8:0]      sum9;
   logic [8:0]      d;
   logic [7:0]      lvl;
   logic [23:0]     rgb_c;

   assign tick = (timer == T_LAST);

   // Frame timer free-runs independent of the sweep state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (tick) begin
         timer <= '0;
      end else begin
         timer <= timer + TW'(1);
      end
   end

   // Pixel render; the k=0 pixel is produced on the start edge, before lq is loaded
   always_comb begin
      k_idx   = (state == IDLE) ? 8'd0 : k;
      lvl_src = (state == IDLE) ? brightness : lq;
      sum9    = {1'b0, head} + N9 - {1'b0, k_idx};
      d       = (sum9 >= N9) ? (sum9 - N9) : sum9;
      lvl     = 8'd0;
      rgb_c   = 24'd0;
      case (d)
         9'd0:    lvl = lvl_src;
         9'd1:    lvl = lvl_src >> 1;
         9'd2:    lvl = lvl_src >> 2;
         default: lvl = 8'd0;
      endcase
      case (c)
         2'd0: rgb_c = {16'd0, lvl};
         2'd1: rgb_c = {8'd0, lvl, 8'd0};
         2'd2: rgb_c = {lvl, 16'd0};
         default: rgb_c = {lvl, lvl, lvl};
      endcase
   end

   // Sweep sequencer with registered strobe outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         k          <= 8'd0;
         lq         <= 8'd0;
         c          <= 2'd0;
         head       <= 8'd0;
         led_num    <= 8'd0;
         rgb_data   <= 24'd0;
         write      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         write      <= 1'b0;
         frame_done <= 1'b0;
         rgb_data   <= 24'd0;
         case (state)
            IDLE: begin
               if (tick && enable) begin
                  state    <= SWEEP;
                  lq       <= brightness;
                  write    <= 1'b1;
                  led_num  <= 8'd0;
                  rgb_data <= rgb_c;
                  k        <= 8'd1;
               end
            end
            SWEEP: begin
               if (k < N8) begin
                  write    <= 1'b1;
                  led_num  <= k;
                  rgb_data <= rgb_c;
                  k        <= k + 8'd1;
               end else begin
                  frame_done <= 1'b1;
                  state      <= DONE;
                  if (head == HEAD_MAX) begin
                     head <= 8'd0;
                     c    <= c + 2'd1;
                  end else begin
                     head <= head + 8'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_comet_seq.sv
// Directed bench for led_comet_seq at NUM_LEDS=5, FRAME_DIV=16.
module tb_led_comet_seq;

   localparam int N  = 5;
   localparam int FD = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [7:0]  brightness = 8'h80;
   logic [7:0]  led_num;
   logic [23:0] rgb_data;
   logic        write;
   logic        frame_done;
   logic [7:0]  head;

   int errors = 0;
   int checks = 0;

   int          m_head = 0;
   int          m_c = 0;
   logic [7:0]  m_lq = 8'h80;
   logic [23:0] cap [N];

   led_comet_seq #(.NUM_LEDS(N), .FRAME_DIV(FD)) dut (
      .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
      .led_num(led_num), .rgb_data(rgb_data), .write(write),
      .frame_done(frame_done), .head(head)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] exp_rgb(int h, int cc, logic [7:0] l, int k);
      logic [7:0] v;
      v = 8'd0;
      if (k == h) v = l;
      else if (k == (h + N - 1) % N) v = l >> 1;
      else if (k == (h + N - 2) % N) v = l >> 2;
      case (cc)
         0: return {16'd0, v};
         1: return {8'd0, v, 8'd0};
         2: return {v, 16'd0};
         default: return {v, v, v};
      endcase
   endfunction

   task automatic wait_write(output int n);
      n = 0;
      while (write !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      if (write !== 1'b1) check("write_timeout", 32'(write), 32'd1);
   endtask

   // Checks one sweep starting at its first write; optional mid-sweep input changes
   task automatic sweep(input int br_at, input int en_off_at);
      logic [7:0] l;
      l = m_lq;
      for (int k = 0; k < N; k++) begin
         check("sweep_write", 32'(write), 32'd1);
         check("sweep_led_num", 32'(led_num), 32'(k));
         check("sweep_rgb", 32'(rgb_data), 32'(exp_rgb(m_head, m_c, l, k)));
         if (k == 0) check("sweep_no_done", 32'(frame_done), 32'd0);
         cap[k] = rgb_data;
         if (k == br_at) brightness = 8'hFF;
         if (k == en_off_at) enable = 1'b0;
         step();
      end
      m_head = (m_head == N - 1) ? 0 : m_head + 1;
      if (m_head == 0) m_c = (m_c + 1) % 4;
      check("done_write", 32'(write), 32'd0);
      check("done_pulse", 32'(frame_done), 32'd1);
      check("done_rgb", 32'(rgb_data), 32'd0);
      check("done_head", 32'(head), 32'(m_head));
      m_lq = brightness;
   endtask

   int n;
   int wcount;
   logic [7:0] held;

   initial begin
      step();
      step();
      check("rst_write", 32'(write), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_led_num", 32'(led_num), 32'd0);
      check("rst_rgb", 32'(rgb_data), 32'd0);
      check("rst_head", 32'(head), 32'd0);
      reset = 1'b0;

      // First sweep lands a full frame after release
      wait_write(n);
      check("first_latency", 32'(n), 32'd16);
      sweep(-1, -1);
      check("h0_k0", 32'(cap[0]), 32'h000080);
      check("h0_k1", 32'(cap[1]), 32'h000000);
      check("h0_k4", 32'(cap[4]), 32'h000040);
      check("h0_k3", 32'(cap[3]), 32'h000020);
      check("done_clears", 32'(frame_done), 32'd1);
      step();
      check("done_one_cycle", 32'(frame_done), 32'd0);

      wait_write(n);
      check("frame_gap", 32'(n), 32'd10);
      sweep(-1, -1);
      check("h1_k1", 32'(cap[1]), 32'h000080);
      check("h1_k0", 32'(cap[0]), 32'h000040);
      check("h1_k4", 32'(cap[4]), 32'h000020);
      check("h1_k2", 32'(cap[2]), 32'h000000);
      check("h1_k3", 32'(cap[3]), 32'h000000);

      for (int s = 3; s <= 5; s++) begin
         wait_write(n);
         sweep(-1, -1);
      end
      check("wrap_head", 32'(head), 32'd0);

      wait_write(n);
      sweep(-1, -1);
      check("c1_head_led", 32'(cap[0]), 32'h008000);

      for (int s = 7; s <= 15; s++) begin
         wait_write(n);
         sweep(-1, -1);
      end

      // Sweep 16: c=3, brightness raised mid-sweep
      wait_write(n);
      sweep(2, -1);
      check("c3_head_led", 32'(cap[0]), 32'h808080);
      check("c3_tail_k4", 32'(cap[4]), 32'h404040);

      wait_write(n);
      sweep(-1, -1);
      check("bright_head", 32'(cap[1]), 32'hFFFFFF);
      check("bright_tail1", 32'(cap[0]), 32'h7F7F7F);
      check("bright_tail2", 32'(cap[4]), 32'h3F3F3F);

      for (int s = 18; s <= 20; s++) begin
         wait_write(n);
         sweep(-1, -1);
      end
      check("c_cycled_head", 32'(head), 32'd0);

      // Sweep 21: colour back to 0, enable dropped mid-sweep
      wait_write(n);
      sweep(-1, 1);
      check("c0_again", 32'(cap[0]), 32'h0000FF);

      held = head;
      wcount = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (write === 1'b1) wcount++;
      end
      check("disabled_no_writes", 32'(wcount), 32'd0);
      check("disabled_head_frozen", 32'(head), 32'(held));

      enable = 1'b1;
      wait_write(n);
      check("reenable_within_frame", 32'(n >= 1 && n <= FD), 32'd1);
      sweep(-1, -1);

      // Reset during the third write of a sweep
      wait_write(n);
      step();
      step();
      check("abort_at_k2", 32'(led_num), 32'd2);
      reset = 1'b1;
      #1;
      check("abort_write", 32'(write), 32'd0);
      check("abort_head", 32'(head), 32'd0);
      check("abort_rgb", 32'(rgb_data), 32'd0);
      m_head = 0;
      m_c = 0;
      m_lq = brightness;
      step();
      step();
      reset = 1'b0;
      wait_write(n);
      check("post_reset_latency", 32'(n), 32'd16);
      sweep(-1, -1);
      check("post_reset_head_led", 32'(cap[0]), 32'h0000FF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
